spi_rw_engine: RTL and testbench
================================

# spi_rw_engine

Serial-side engine of the SPI register bridge, clocked directly by SCLK. It decodes a 6-bit command header from MOSI and then either streams memory bytes out on MISO (read burst) or deserialises 28-bit words from MOSI and writes them to memory (write burst). It sits between the SPI pins and the 64-entry coefficient memory, and groups the header decoder, read controller and write controller behind one FSM.

## Interface
- RD_WORDS, 64: words per read burst (1..64).
- WR_WORDS, 64: words per write burst (1..64).

- iCLK  in  1  SCLK; all logic on rising edge.
- iRSTn  in  1  reset. One clock; reset is asynchronous and active-low.
- iCLR  in  1  synchronous clear; same effect as reset, has priority over all other logic.
- CS  in  1  chip select, active low.
- MOSI  in  1  serial data in, MSB first.
- iDATA  in  28  memory read data; combinational (same-cycle) response to oADDR/oRd_EN; only [7:0] used.
- MISO  out  1  serial data out, MSB first.
- oADDR  out  6  memory address.
- oRd_EN  out  1  memory read strobe.
- oDATA  out  28  memory write data.
- oWr_EN  out  1  memory write strobe, one cycle per word.
- oRd_DONE  out  1  read-burst-complete pulse.
- oWr_DONE  out  1  write-burst-complete pulse.

## Operation
- States IDLE, HEADER, READ, WRITE. Reset/iCLR: IDLE, all counters, shift registers, MISO, oDATA, oRd_DONE, oWr_DONE, oWr_EN = 0.
- IDLE: CS sampled 0 -> HEADER. CS is ignored in every other state; a transfer ends only by count or by iCLR/reset.
- HEADER: MOSI shifted in on 6 edges, MSB first. On the 6th edge the full header (5 shifted bits plus current MOSI) is decoded:
  - 6'd0 -> READ.
  - 6'd1 -> WRITE.
  - Any other value -> IDLE.
- READ: number the READ edges k = 0..8·RD_WORDS-1.
  - In the cycle before edge k with k%8 == 0: oRd_EN = 1 and oADDR = k/8.
  - At that edge the shift register loads iDATA[7:0]; on all other READ edges it shifts left.
  - MISO = shift register [7].
  - Edge 8·RD_WORDS-1 -> IDLE and sets oRd_DONE for one cycle. That cycle carries bit 0 of the last byte.
  - The shift register holds its value after READ; MISO keeps the last bit until the next load or clear.
- WRITE: the first 2 edges are turnaround and MOSI is ignored. Then 28 edges per word, MSB first, into a shift register.
  - On the 28th edge of word w: oDATA <= complete word and oWr_EN = 1 for the next cycle, with oADDR = w in that cycle.
  - On the last word's 28th edge: -> IDLE, and oWr_DONE pulses in the same cycle as the final oWr_EN.
  - oDATA holds its last value.
- oADDR = read address while oRd_EN; = write address while oWr_EN; else 0. oRd_EN = 0 outside READ.

## Timing
- Header latency: the CS-low sampling edge does not carry a header bit. The header occupies the next 6 edges; the first READ/WRITE cycle follows immediately.
- Read: 8·RD_WORDS READ cycles. First MISO bit (bit 7 of address 0) appears in the cycle after the first READ edge.
- Write: 2 + 28·WR_WORDS WRITE edges. oWr_EN is registered, 1 cycle after the 28th bit edge.
- iCLR mid-burst: next cycle is IDLE with outputs cleared; no DONE pulse. A partial write word is never written.
- A new transfer may start on the edge after DONE if CS is low.

## Structure
- Shared package: state encoding (IDLE=0, HEADER=1, READ=2, WRITE=3), CMD_READ=6'd0, CMD_WRITE=6'd1, HDR_BITS=6, RD_BITS=8, WR_BITS=28, WR_GAP=2.
- Natural sub-module: one generic shift-register/bit-counter unit `spi_shift_cnt`, instantiated for header, read and write paths. The FSM and address mux live at top level.

## Test plan
- Reset and iCLR asserted mid-burst -> all outputs 0 and state IDLE on the next cycle; no DONE pulse.
- RD_WORDS=2, header 000000, memory[0]=0xA5, memory[1]=0x3C -> oRd_EN with oADDR 0 then 1; MISO bits 1010_0101_0011_1100; oRd_DONE coincides with the final 0.
- WR_WORDS=2, header 000001, 2 dummy bits, words 0x8000001 and 0x123ABCD -> oWr_EN at addr 0 and 1 with those oDATA values; oWr_DONE with the second oWr_EN.
- Header 000101 -> return to IDLE after 6 bits; no strobes, MISO stays 0.
- CS raised mid-read -> burst still completes full count; back-to-back write immediately after oRd_DONE decodes correctly.

Source files
------------

// File: rtl/spi_rw_engine_pkg.sv
// -----------------------------------------------------------------------------
// spi_rw_engine_pkg
// Shared definitions for the SPI register-bridge serial engine: FSM state
// encoding, command codes, field widths and the header decode helper.
// -----------------------------------------------------------------------------
package spi_rw_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_READ   = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  localparam logic [5:0] CMD_READ  = 6'd0;
  localparam logic [5:0] CMD_WRITE = 6'd1;

  localparam int HDR_BITS = 6;   // command header length
  localparam int RD_BITS  = 8;   // bits per read byte on MISO
  localparam int WR_BITS  = 28;  // bits per write word on MOSI
  localparam int WR_GAP   = 2;   // turnaround edges before the first write bit

  localparam int ADDR_W = 6;     // 64-entry coefficient memory
  localparam int DATA_W = 28;

  // Map a complete header onto the state that follows it; unknown commands
  // drop straight back to IDLE.
  function automatic state_e decode_cmd(input logic [HDR_BITS-1:0] cmd);
    case (cmd)
      CMD_READ:  return ST_READ;
      CMD_WRITE: return ST_WRITE;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/spi_rw_engine_if.sv
// -----------------------------------------------------------------------------
// spi_rw_engine_if
// Bundles the SPI pins and the coefficient-memory port of the engine.
//   CS, MOSI   : SPI chip select (active low) and serial data in
//   MISO       : SPI serial data out
//   iDATA      : memory read data (combinational response to oADDR/oRd_EN)
//   oADDR      : memory address
//   oRd_EN     : memory read strobe
//   oDATA      : memory write data
//   oWr_EN     : memory write strobe, one cycle per word
//   oRd_DONE   : read-burst-complete pulse
//   oWr_DONE   : write-burst-complete pulse
// master = the engine, slave = the pins/memory side.
// -----------------------------------------------------------------------------
interface spi_rw_engine_if;
  import spi_rw_engine_pkg::*;

  logic              CS;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] iDATA;
  logic [ADDR_W-1:0] oADDR;
  logic              oRd_EN;
  logic [DATA_W-1:0] oDATA;
  logic              oWr_EN;
  logic              oRd_DONE;
  logic              oWr_DONE;

  modport master (
    input  CS, MOSI, iDATA,
    output MISO, oADDR, oRd_EN, oDATA, oWr_EN, oRd_DONE, oWr_DONE
  );

  modport slave (
    output CS, MOSI, iDATA,
    input  MISO, oADDR, oRd_EN, oDATA, oWr_EN, oRd_DONE, oWr_DONE
  );

endinterface

// File: rtl/spi_rw_engine_shift.sv
// -----------------------------------------------------------------------------
// spi_shift_cnt
// Generic MSB-first shift register with a modulo-COUNT bit counter. Used for
// the header, read and write paths of spi_rw_engine.
//   iCLK, iRSTn : clock, asynchronous active-low reset
//   iCLR        : synchronous clear (priority over step)
//   step        : advance the counter and shift (or load) this edge
//   load        : with step, load load_val instead of shifting
//   load_val    : parallel load value
//   din         : serial input, enters at bit 0
//   sr          : shift register contents
//   first, last : counter is at 0 / at COUNT-1 (last step of a group)
// -----------------------------------------------------------------------------
module spi_shift_cnt #(
  parameter int WIDTH = 8,
  parameter int COUNT = 8
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iCLR,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             din,
  output logic [WIDTH-1:0] sr,
  output logic             first,
  output logic             last
);

  localparam int CW = $clog2(COUNT);

  logic [CW-1:0] cnt;

  assign first = (cnt == '0);
  assign last  = (cnt == CW'(COUNT - 1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cnt <= '0;
      sr  <= '0;
    end else if (iCLR) begin
      cnt <= '0;
      sr  <= '0;
    end else if (step) begin
      // The counter wraps on its own, so a path leaving by count is already
      // back at zero for the next transfer.
      cnt <= last ? '0 : cnt + CW'(1);
      sr  <= load ? load_val : {sr[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/spi_rw_engine.sv
// -----------------------------------------------------------------------------
// spi_rw_engine
// Serial-side engine of the SPI register bridge, clocked by SCLK. Decodes a
// 6-bit command header from MOSI, then streams memory bytes on MISO (read
// burst) or deserialises 28-bit words from MOSI into memory (write burst).
//   iCLK  : SCLK, all logic on the rising edge
//   iRSTn : asynchronous active-low reset
//   iCLR  : synchronous clear, same effect as reset, highest priority
//   bus   : SPI pins + memory port (spi_rw_engine_if.master)
// Parameters: RD_WORDS / WR_WORDS words per read / write burst (1..64).
// -----------------------------------------------------------------------------
module spi_rw_engine
  import spi_rw_engine_pkg::*;
#(
  parameter int RD_WORDS = 64,
  parameter int WR_WORDS = 64
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iCLR,
  spi_rw_engine_if.master bus
);

  localparam int GAP_W = $clog2(WR_GAP + 1);

  state_e state, state_nxt;

  logic                hdr_step, rd_step, wr_step, rd_en;
  logic                hdr_first, hdr_last, rd_first, rd_last, wr_first, wr_last;
  logic [HDR_BITS-2:0] hdr_sr;
  logic [RD_BITS-1:0]  rd_sr;
  logic [WR_BITS-2:0]  wr_sr;

  logic [ADDR_W-1:0]   rd_word, wr_word, wr_addr_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic                gap_done;
  logic                rd_end, wr_word_done, wr_end;

  logic [DATA_W-1:0]   data_q;
  logic                wr_en_q, rd_done_q, wr_done_q;

  // Header: the 6th bit is taken straight from MOSI, so only 5 bits are stored.
  spi_shift_cnt #(.WIDTH(HDR_BITS - 1), .COUNT(HDR_BITS)) u_hdr (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR),
    .step(hdr_step), .load(1'b0), .load_val('0), .din(bus.MOSI),
    .sr(hdr_sr), .first(hdr_first), .last(hdr_last)
  );

  // Read: load the memory byte on the first edge of each byte, then shift out.
  spi_shift_cnt #(.WIDTH(RD_BITS), .COUNT(RD_BITS)) u_rd (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR),
    .step(rd_step), .load(rd_first), .load_val(bus.iDATA[RD_BITS-1:0]), .din(1'b0),
    .sr(rd_sr), .first(rd_first), .last(rd_last)
  );

  // Write: as with the header, the final bit of a word comes directly from MOSI.
  spi_shift_cnt #(.WIDTH(WR_BITS - 1), .COUNT(WR_BITS)) u_wr (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR),
    .step(wr_step), .load(1'b0), .load_val('0), .din(bus.MOSI),
    .sr(wr_sr), .first(wr_first), .last(wr_last)
  );

  assign gap_done     = (gap_cnt == GAP_W'(WR_GAP));
  assign rd_end       = rd_step && rd_last && (rd_word == ADDR_W'(RD_WORDS - 1));
  assign wr_word_done = wr_step && wr_last;
  assign wr_end       = wr_word_done && (wr_word == ADDR_W'(WR_WORDS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn)    state <= ST_IDLE;
    else if (iCLR) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. CS only matters in IDLE; bursts end by count alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!bus.CS)  state_nxt = ST_HEADER;
      ST_HEADER: if (hdr_last) state_nxt = decode_cmd({hdr_sr, bus.MOSI});
      ST_READ:   if (rd_end)   state_nxt = ST_IDLE;
      ST_WRITE:  if (wr_end)   state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath enables
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    hdr_step = 1'b0;
    rd_step  = 1'b0;
    wr_step  = 1'b0;
    rd_en    = 1'b0;
    case (state)
      ST_HEADER: hdr_step = 1'b1;
      ST_READ: begin
        rd_step = 1'b1;
        rd_en   = rd_first;  // memory read happens in the cycle before the load edge
      end
      ST_WRITE:  wr_step = gap_done;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word counters, turnaround counter and registered write-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      rd_word   <= '0;
      wr_word   <= '0;
      wr_addr_q <= '0;
      gap_cnt   <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else if (iCLR) begin
      rd_word   <= '0;
      wr_word   <= '0;
      wr_addr_q <= '0;
      gap_cnt   <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      rd_done_q <= rd_end;
      wr_en_q   <= wr_word_done;
      wr_done_q <= wr_end;

      if (rd_step && rd_last)
        rd_word <= rd_end ? '0 : rd_word + ADDR_W'(1);

      // Counts the turnaround edges, then parks until WRITE is left.
      if (state == ST_WRITE) begin
        if (!gap_done) gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end

      // The strobe is registered, so the address of the completed word is
      // captured alongside the data before the word counter moves on.
      if (wr_word_done) begin
        data_q    <= {wr_sr, bus.MOSI};
        wr_addr_q <= wr_word;
        wr_word   <= wr_end ? '0 : wr_word + ADDR_W'(1);
      end
    end
  end

  assign bus.MISO     = rd_sr[RD_BITS-1];
  assign bus.oRd_EN   = rd_en;
  assign bus.oWr_EN   = wr_en_q;
  assign bus.oDATA    = data_q;
  assign bus.oRd_DONE = rd_done_q;
  assign bus.oWr_DONE = wr_done_q;
  assign bus.oADDR    = rd_en   ? rd_word   :
                        wr_en_q ? wr_addr_q : '0;

  // Bits each path does not need, collected so they read as deliberately dropped.
  logic unused_ok;
  assign unused_ok = ^{hdr_first, wr_first, rd_sr[RD_BITS-2:0], bus.iDATA[DATA_W-1:RD_BITS]};

endmodule

// File: tb/tb_spi_rw_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_rw_engine
// Self-checking bench for spi_rw_engine with RD_WORDS = WR_WORDS = 2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected memory strobes go into queues when a burst is driven and are popped
// by a monitor as the DUT raises oRd_EN / oWr_EN.
// -----------------------------------------------------------------------------
module tb_spi_rw_engine;
  import spi_rw_engine_pkg::*;

  localparam int RD_WORDS = 2;
  localparam int WR_WORDS = 2;
  localparam int RD_CYC   = RD_WORDS * RD_BITS;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } wr_exp_t;

  logic iCLK  = 1'b0;
  logic iRSTn = 1'b0;
  logic iCLR  = 1'b0;

  spi_rw_engine_if bus();

  spi_rw_engine #(.RD_WORDS(RD_WORDS), .WR_WORDS(WR_WORDS)) dut (
    .iCLK (iCLK),
    .iRSTn(iRSTn),
    .iCLR (iCLR),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  // Memory seen by the DUT (upper bits deliberately non-zero) and the bench's
  // own record of what should be stored there.
  logic [DATA_W-1:0] mem     [64] = '{0: 28'hABCDEA5, 1: 28'h765433C, default: '0};
  logic [DATA_W-1:0] ref_mem [64] = '{0: 28'hABCDEA5, 1: 28'h765433C, default: '0};

  always @(posedge iCLK) if (bus.oWr_EN) mem[bus.oADDR] <= bus.oDATA;
  assign bus.iDATA = mem[bus.oADDR];

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] rd_q[$];
  wr_exp_t           wr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: memory strobes against the queues, idle address and lone DONE.
  always @(negedge iCLK) begin
    if (iRSTn) begin
      if (bus.oRd_EN) begin
        if (rd_q.size() == 0) check("rd_en_spurious", 32'(bus.oRd_EN), 32'd0);
        else                  check("rd_addr", 32'(bus.oADDR), 32'(rd_q.pop_front()));
      end
      if (bus.oWr_EN) begin : pop_wr
        wr_exp_t e;
        if (wr_q.size() == 0) begin
          check("wr_en_spurious", 32'(bus.oWr_EN), 32'd0);
        end else begin
          e = wr_q.pop_front();
          check("wr_addr", 32'(bus.oADDR), 32'(e.addr));
          check("wr_data", 32'(bus.oDATA), 32'(e.data));
          check("wr_done", 32'(bus.oWr_DONE), 32'(e.last));
        end
      end else begin
        check("wr_done_alone", 32'(bus.oWr_DONE), 32'd0);
      end
      if (!bus.oRd_EN && !bus.oWr_EN) check("addr_idle", 32'(bus.oADDR), 32'd0);
    end
  end

  // Drive one SCLK cycle worth of pins, ending on the following falling edge.
  task automatic cyc(input logic cs, input logic mosi);
    bus.CS   = cs;
    bus.MOSI = mosi;
    @(negedge iCLK);
  endtask

  // The CS-low sampling edge carries no header bit; MOSI is set to the
  // opposite of the first header bit there so a stray capture shows up.
  task automatic send_header(input logic [HDR_BITS-1:0] h);
    cyc(1'b0, ~h[HDR_BITS-1]);
    for (int i = HDR_BITS - 1; i >= 0; i--) cyc(1'b0, h[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_miso"},     32'(bus.MISO),     32'd0);
    check({tag, "_addr"},     32'(bus.oADDR),    32'd0);
    check({tag, "_rd_en"},    32'(bus.oRd_EN),   32'd0);
    check({tag, "_data"},     32'(bus.oDATA),    32'd0);
    check({tag, "_wr_en"},    32'(bus.oWr_EN),   32'd0);
    check({tag, "_rd_done"},  32'(bus.oRd_DONE), 32'd0);
    check({tag, "_wr_done"},  32'(bus.oWr_DONE), 32'd0);
  endtask

  // CS high, random MOSI: the engine must stay quiet and MISO must hold.
  task automatic idle_cycles(input int n, input logic exp_miso);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)));
      check("idle_miso",    32'(bus.MISO),     32'(exp_miso));
      check("idle_rd_done", 32'(bus.oRd_DONE), 32'd0);
    end
  endtask

  // Read burst; CS goes high from bit cs_rise_at onward, and the task stops
  // after abort_at bits so the caller can clear the engine mid-burst.
  task automatic read_burst(input int cs_rise_at, input int abort_at);
    logic [RD_CYC-1:0] bits;
    for (int w = 0; w < RD_WORDS; w++) begin
      bits[RD_CYC-1-RD_BITS*w -: RD_BITS] = ref_mem[w][RD_BITS-1:0];
      if (RD_BITS * w <= abort_at) rd_q.push_back(ADDR_W'(w));
    end
    send_header(CMD_READ);
    for (int i = 0; i < RD_CYC && i < abort_at; i++) begin
      cyc((i >= cs_rise_at) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
      check("miso",    32'(bus.MISO),     32'(bits[RD_CYC-1-i]));
      check("rd_done", 32'(bus.oRd_DONE), 32'(i == RD_CYC - 1));
    end
  endtask

  // Write burst of two words; abort_bits >= 0 stops after that many data bits.
  task automatic write_burst(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                             input int abort_bits);
    logic [DATA_W-1:0] wd [WR_WORDS];
    int n;
    wd[0] = w0;
    wd[1] = w1;
    if (abort_bits < 0) begin
      for (int w = 0; w < WR_WORDS; w++) begin
        wr_q.push_back('{addr: ADDR_W'(w), data: wd[w], last: (w == WR_WORDS - 1)});
        ref_mem[w] = wd[w];
      end
    end
    send_header(CMD_WRITE);
    cyc(1'b0, 1'b1);  // turnaround bits, must be ignored
    cyc(1'b0, 1'b1);
    n = 0;
    for (int w = 0; w < WR_WORDS; w++) begin
      for (int b = WR_BITS - 1; b >= 0; b--) begin
        if (abort_bits >= 0 && n == abort_bits) return;
        cyc(1'b0, wd[w][b]);
        n++;
      end
    end
  endtask

  initial begin
    bus.CS   = 1'b1;
    bus.MOSI = 1'b0;

    // Reset state
    repeat (3) @(negedge iCLK);
    check_zero("reset");
    iRSTn = 1'b1;
    @(negedge iCLK);

    // Unknown command: back to IDLE after 6 bits, no strobes, MISO stays 0
    send_header(6'b000101);
    idle_cycles(10, 1'b0);

    // Read 0xA5, 0x3C with CS raised mid-burst, then back-to-back write
    read_burst(4, RD_CYC);
    write_burst(28'h8000001, 28'h123ABCD, -1);
    idle_cycles(4, 1'b0);  // MISO keeps bit 0 of 0x3C

    // Read back the written words: low bytes 0x01, 0xCD
    read_burst(RD_CYC, RD_CYC);
    idle_cycles(3, 1'b1);  // MISO keeps bit 0 of 0xCD

    // iCLR in the middle of a write word: nothing written, all cleared
    write_burst(28'hFFFFFFF, 28'h0000000, 10);
    iCLR = 1'b1;
    cyc(1'b1, 1'b1);
    iCLR = 1'b0;
    check_zero("clr");
    idle_cycles(40, 1'b0);

    // Asynchronous reset in the middle of a read
    read_burst(RD_CYC, 12);
    #2 iRSTn = 1'b0;
    #1 check_zero("async_rst");
    @(negedge iCLK);
    #2 iRSTn = 1'b1;
    @(negedge iCLK);
    idle_cycles(10, 1'b0);

    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
